// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the single-clock FIFO.
//   ptr_width()             - pointer width (address bits plus one wrap bit)
//   DEFAULT_*               - default word width, depth and flag thresholds
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_ADDR_WIDTH    = 10;
    // almost_full default sits this many words below DEPTH
    localparam int DEFAULT_AFULL_MARGIN  = 4;
    localparam int DEFAULT_AEMPTY_THRESH = 4;

    // Read/write pointers carry one extra MSB so full and empty can be told apart
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port storage array for sync_fifo.
// Build option: SYNC_FIFO_FWFT_EN selects an asynchronous read port.
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write enable; stores wr_data at wr_addr
//   wr_addr  - write address
//   wr_data  - write word
//   rd_en    - (standard build) load the read register from rd_addr
//   rd_clr   - (standard build) synchronous clear of the read register
//   rd_addr  - read address
//   rd_data  - read word (registered in standard build, combinational in FWFT)
// The array itself is never reset; only the read register is cleared.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                  rd_en,
    input  logic                  rd_clr,
`endif
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented straight from the array
    assign rd_data = mem_r[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Registered read port; a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with programmable almost-full/almost-empty
// flags, sticky overflow/underflow flags and a synchronous flush.
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// undefined gives registered reads with a one-cycle rd_valid pulse.
// Ports:
//   fifo_clk      - clock, rising edge
//   fifo_rst_n    - synchronous active-low reset
//   clr           - synchronous flush, active-high
//   wr_req/wr_data- write strobe and word
//   rd_req        - read (pop) strobe
//   rd_data       - read word
//   rd_valid      - rd_data is valid
//   full, empty, almost_full, almost_empty - status flags
//   use_num       - occupancy 0..DEPTH
//   overflow, underflow - sticky error flags, cleared by clr or reset
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst_n,
    input  logic                  clr,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   use_num,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             PTR_W       = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] AFULL_CMP = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_CMP = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, use_num_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s, use_num_nxt_s;
    logic             full_r, empty_r, almost_full_r, almost_empty_r;
    logic             full_nxt_s, empty_nxt_s, almost_full_nxt_s, almost_empty_nxt_s;
    logic             overflow_r, underflow_r;
    logic             flush_s, rd_accept_s, wr_accept_s;

    // Reset and flush both discard any request in the same cycle
    assign flush_s     = !fifo_rst_n || clr;
    assign rd_accept_s = rd_req && !empty_r && !flush_s;
    // A full FIFO still takes a write when a read frees a slot this cycle
    assign wr_accept_s = wr_req && (!full_r || rd_accept_s) && !flush_s;

    // Next pointers, occupancy and flags, evaluated from the post-edge pointers
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_accept_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_accept_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        use_num_nxt_s      = wr_ptr_nxt_s - rd_ptr_nxt_s;
        empty_nxt_s        = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s         = (wr_ptr_nxt_s[PTR_W-1] != rd_ptr_nxt_s[PTR_W-1]) &&
                             (wr_ptr_nxt_s[ADDR_WIDTH-1:0] == rd_ptr_nxt_s[ADDR_WIDTH-1:0]);
        almost_full_nxt_s  = (use_num_nxt_s >= AFULL_CMP);
        almost_empty_nxt_s = (use_num_nxt_s <= AEMPTY_CMP);
    end

    // Pointer, occupancy and status-flag registers
    always_ff @(posedge fifo_clk) begin
        if (flush_s) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            use_num_r      <= '0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            use_num_r      <= use_num_nxt_s;
            empty_r        <= empty_nxt_s;
            almost_empty_r <= almost_empty_nxt_s;
            full_r         <= full_nxt_s;
            almost_full_r  <= almost_full_nxt_s;
        end
    end

    // Sticky error flags: dropped write while full, read while empty
    always_ff @(posedge fifo_clk) begin
        if (flush_s) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  || (wr_req && !wr_accept_s);
            underflow_r <= underflow_r || (rd_req && empty_r);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (fifo_clk),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // Head word is valid whenever anything is stored
    assign rd_valid = !empty_r;
`else
    logic rd_valid_r;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (fifo_clk),
        .wr_en   (wr_accept_s),
        .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept_s),
        .rd_clr  (flush_s),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // One-cycle valid pulse aligned with the registered read word
    always_ff @(posedge fifo_clk) begin
        if (flush_s) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept_s;
        end
    end

    assign rd_valid = rd_valid_r;
`endif

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign use_num      = use_num_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo with DEPTH=16,
// AFULL_THRESH=12, AEMPTY_THRESH=4. Follows SYNC_FIFO_FWFT_EN for the read mode.
module tb_sync_fifo;

    logic        fifo_clk = 1'b0;
    logic        fifo_rst_n;
    logic        clr;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full, empty, almost_full, almost_empty;
    logic [4:0]  use_num;
    logic        overflow, underflow;

    int test_cnt = 0;
    int fail_cnt = 0;

    sync_fifo #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (4),
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (4)
    ) dut (
        .fifo_clk     (fifo_clk),
        .fifo_rst_n   (fifo_rst_n),
        .clr          (clr),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .use_num      (use_num),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge and settle so outputs can be sampled
    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_use_num"},   32'(use_num),   32'd0);
        check_val({tag, "_empty"},     32'(empty),     32'd1);
        check_val({tag, "_aempty"},    32'(almost_empty), 32'd1);
        check_val({tag, "_full"},      32'(full),      32'd0);
        check_val({tag, "_afull"},     32'(almost_full), 32'd0);
        check_val({tag, "_overflow"},  32'(overflow),  32'd0);
        check_val({tag, "_underflow"}, 32'(underflow), 32'd0);
        check_val({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    endtask

    initial begin
        fifo_rst_n = 1'b0;
        clr        = 1'b0;
        wr_req     = 1'b0;
        wr_data    = 16'h0000;
        rd_req     = 1'b0;
        tick();
        tick();
        check_cleared("reset");
`ifndef SYNC_FIFO_FWFT_EN
        check_val("reset_rd_data", 32'(rd_data), 32'h0);
`endif
        fifo_rst_n = 1'b1;

        // Fill 0x0001..0x0010 and watch the flag thresholds
        for (int i = 1; i <= 16; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'(i);
            tick();
            check_val($sformatf("fill_use_num_%0d", i), 32'(use_num), 32'(i));
            check_val($sformatf("fill_afull_%0d", i),   32'(almost_full),  (i >= 12) ? 32'd1 : 32'd0);
            check_val($sformatf("fill_full_%0d", i),    32'(full),         (i == 16) ? 32'd1 : 32'd0);
            check_val($sformatf("fill_aempty_%0d", i),  32'(almost_empty), (i <= 4)  ? 32'd1 : 32'd0);
        end

        // Overflow: write while full with no read is dropped
        wr_data = 16'hDEAD;
        tick();
        wr_req = 1'b0;
        check_val("ovf_flag",    32'(overflow), 32'd1);
        check_val("ovf_use_num", 32'(use_num),  32'd16);
        check_val("ovf_full",    32'(full),     32'd1);

`ifdef SYNC_FIFO_FWFT_EN
        // Drain: head word visible before each pop
        for (int i = 1; i <= 16; i++) begin
            check_val($sformatf("drain_valid_%0d", i), 32'(rd_valid), 32'd1);
            check_val($sformatf("drain_data_%0d", i),  32'(rd_data),  32'(i));
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        check_val("drain_empty",    32'(empty),    32'd1);
        check_val("drain_rd_valid", 32'(rd_valid), 32'd0);

        // First-word fall-through
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_cleared("fwft_clr");
        wr_req  = 1'b1;
        wr_data = 16'h1234;
        tick();
        wr_req = 1'b0;
        check_val("fwft_valid", 32'(rd_valid), 32'd1);
        check_val("fwft_data",  32'(rd_data),  32'h1234);
        tick();
        check_val("fwft_hold_valid", 32'(rd_valid), 32'd1);
        check_val("fwft_hold_data",  32'(rd_data),  32'h1234);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_val("fwft_pop_empty", 32'(empty),    32'd1);
        check_val("fwft_pop_valid", 32'(rd_valid), 32'd0);
        check_val("fwft_pop_num",   32'(use_num),  32'd0);
`else
        // Drain: data returns in order, no 0xDEAD
        for (int i = 1; i <= 16; i++) begin
            rd_req = 1'b1;
            tick();
            check_val($sformatf("drain_valid_%0d", i), 32'(rd_valid), 32'd1);
            check_val($sformatf("drain_data_%0d", i),  32'(rd_data),  32'(i));
        end
        rd_req = 1'b0;
        check_val("drain_empty", 32'(empty), 32'd1);
        tick();
        check_val("drain_idle_valid", 32'(rd_valid), 32'd0);
        check_val("drain_hold_data",  32'(rd_data),  32'h0010);

        // Underflow: read while empty
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_val("udf_flag",     32'(underflow), 32'd1);
        check_val("udf_rd_valid", 32'(rd_valid),  32'd0);
        check_val("udf_use_num",  32'(use_num),   32'd0);
        check_val("udf_ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous read and write while full
        for (int i = 0; i < 16; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'h0100 + 16'(i);
            tick();
        end
        check_val("sim_full_pre", 32'(full), 32'd1);
        wr_data = 16'h00AA;
        rd_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        check_val("sim_full_use_num", 32'(use_num),  32'd16);
        check_val("sim_full_full",    32'(full),     32'd1);
        check_val("sim_full_data",    32'(rd_data),  32'h0100);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_val($sformatf("sim_drain_%0d", i), 32'(rd_data),
                      (i == 16) ? 32'h00AA : 32'h0100 + 32'(i));
        end
        rd_req = 1'b0;
        check_val("sim_drain_empty", 32'(empty), 32'd1);

        // Flush, then simultaneous access while empty: only the write proceeds
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_cleared("clr1");
        check_val("clr1_rd_data", 32'(rd_data), 32'h0);
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 16'h0055;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        check_val("sim_empty_use_num",  32'(use_num),   32'd1);
        check_val("sim_empty_udf",      32'(underflow), 32'd1);
        check_val("sim_empty_rd_valid", 32'(rd_valid),  32'd0);

        // Wrap-around stream at occupancy 3
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'h2000 + 16'(i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            wr_req  = 1'b1;
            rd_req  = 1'b1;
            wr_data = 16'h2004 + 16'(k);
            tick();
            check_val($sformatf("wrap_data_%0d", k),    32'(rd_data), 32'h2001 + 32'(k));
            check_val($sformatf("wrap_use_num_%0d", k), 32'(use_num), 32'd3);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Flush mid-burst with pending errors and requests
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_val("flush_udf_pre", 32'(underflow), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'h3000 + 16'(i);
            tick();
        end
        check_val("flush_use_num_pre", 32'(use_num), 32'd9);
        clr    = 1'b1;
        rd_req = 1'b1;
        tick();
        clr    = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        check_cleared("flush");
        check_val("flush_rd_data", 32'(rd_data), 32'h0);
        tick();
        check_val("flush_next_valid", 32'(rd_valid), 32'd0);
        check_val("flush_next_num",   32'(use_num),   32'd0);

        // Reset during a read
        for (int i = 1; i <= 5; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'h4000 + 16'(i);
            tick();
        end
        wr_req     = 1'b0;
        rd_req     = 1'b1;
        fifo_rst_n = 1'b0;
        tick();
        fifo_rst_n = 1'b1;
        rd_req     = 1'b0;
        check_cleared("rst_mid");
        tick();
        check_val("rst_next_valid", 32'(rd_valid), 32'd0);
        check_val("rst_next_empty", 32'(empty),    32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
